// File: rtl/uart_alu_ctrl_if.sv
// Handshake bundle between the UART/ALU controller and its RX FIFO, TX FIFO and
// external combinational ALU.
interface uart_alu_ctrl_if #(
  parameter int DATA_W = 8,
  parameter int OP_W   = 6
);
  logic              rx_empty;
  logic [DATA_W-1:0] r_data;
  logic              rd_uart;
  logic              tx_full;
  logic              wr_uart;
  logic [DATA_W-1:0] w_data;
  logic [DATA_W-1:0] alu_a;
  logic [DATA_W-1:0] alu_b;
  logic [OP_W-1:0]   alu_op;
  logic [DATA_W-1:0] alu_result;
  logic              busy;

  modport master (
    input  rx_empty, r_data, tx_full, alu_result,
    output rd_uart, wr_uart, w_data, alu_a, alu_b, alu_op, busy
  );

  modport slave (
    output rx_empty, r_data, tx_full, alu_result,
    input  rd_uart, wr_uart, w_data, alu_a, alu_b, alu_op, busy
  );
endinterface

// File: rtl/uart_alu_ctrl.sv
// Collects operand A, operand B and opcode bytes from the UART RX FIFO, runs them
// through an external combinational ALU and pushes the result byte to the TX FIFO.
module uart_alu_ctrl #(
  parameter int DATA_W = 8,
  parameter int OP_W   = 6
) (
  input  logic            CLK,
  input  logic            RESET,
  uart_alu_ctrl_if.master bus
);
  typedef enum logic [2:0] {WAIT_A, WAIT_B, WAIT_OP, EXEC, SEND} state_t;

  state_t            r_state;
  state_t            w_next;
  logic              r_run;
  logic              w_pop;
  logic              w_push;
  logic [DATA_W-1:0] r_a;
  logic [DATA_W-1:0] r_b;
  logic [OP_W-1:0]   r_op;
  logic [DATA_W-1:0] r_res;

  // r_run keeps both strobes low until the first clock edge after reset release.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state <= WAIT_A;
      r_run   <= 1'b0;
      r_a     <= '0;
      r_b     <= '0;
      r_op    <= '0;
      r_res   <= '0;
    end else begin
      r_run   <= 1'b1;
      r_state <= w_next;
      if (w_pop) begin
        case (r_state)
          WAIT_A:  r_a  <= bus.r_data;
          WAIT_B:  r_b  <= bus.r_data;
          WAIT_OP: r_op <= bus.r_data[OP_W-1:0];
          default: ;
        endcase
      end
      if (r_state == EXEC) begin
        r_res <= bus.alu_result;
      end
    end
  end

  always_comb begin
    w_next = r_state;
    w_pop  = 1'b0;
    w_push = 1'b0;
    case (r_state)
      WAIT_A: begin
        if (r_run && !bus.rx_empty) begin
          w_pop  = 1'b1;
          w_next = WAIT_B;
        end
      end
      WAIT_B: begin
        if (r_run && !bus.rx_empty) begin
          w_pop  = 1'b1;
          w_next = WAIT_OP;
        end
      end
      WAIT_OP: begin
        if (r_run && !bus.rx_empty) begin
          w_pop  = 1'b1;
          w_next = EXEC;
        end
      end
      EXEC: begin
        w_next = SEND;
      end
      SEND: begin
        if (r_run && !bus.tx_full) begin
          w_push = 1'b1;
          w_next = WAIT_A;
        end
      end
      default: begin
        w_next = WAIT_A;
      end
    endcase
  end

  assign bus.rd_uart = w_pop;
  assign bus.wr_uart = w_push;
  assign bus.w_data  = r_res;
  assign bus.alu_a   = r_a;
  assign bus.alu_b   = r_b;
  assign bus.alu_op  = r_op;
  assign bus.busy    = (r_state == EXEC) || (r_state == SEND);
endmodule

// File: tb/tb_uart_alu_ctrl.sv
// Directed bench for uart_alu_ctrl: RX/TX FIFO models, an add/subtract ALU stub,
// a vector table of single transactions and hand-written multi-cycle sequences.
module tb_uart_alu_ctrl;
  localparam int DATA_W = 8;
  localparam int OP_W   = 6;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] op;
    logic [7:0] res;
    logic [5:0] exp_op;
  } vec_t;

  logic CLK   = 1'b0;
  logic RESET = 1'b0;

  uart_alu_ctrl_if #(.DATA_W(DATA_W), .OP_W(OP_W)) bus ();

  uart_alu_ctrl #(.DATA_W(DATA_W), .OP_W(OP_W)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  always #5 CLK = ~CLK;

  // ALU stub: 0x20 = A+B, 0x22 = A-B, anything else 0.
  always_comb begin
    case (bus.alu_op)
      6'h20:   bus.alu_result = bus.alu_a + bus.alu_b;
      6'h22:   bus.alu_result = bus.alu_a - bus.alu_b;
      default: bus.alu_result = '0;
    endcase
  end

  logic [7:0] rx_q[$];
  logic [7:0] pend_q[$];
  logic [7:0] tx_q[$];
  int         rd_cyc[$];
  int         tx_cyc[$];
  int         cyc     = 0;
  int         n_viol  = 0;
  int         n_tests = 0;
  int         n_fail  = 0;
  bit         pop_req = 1'b0;

  initial begin
    bus.rx_empty = 1'b1;
    bus.r_data   = '0;
    bus.tx_full  = 1'b0;
  end

  // Strobe monitor, sampled mid-cycle while all inputs are stable.
  always @(negedge CLK) begin
    cyc++;
    if (bus.rd_uart) begin
      rd_cyc.push_back(cyc);
      pop_req = 1'b1;
      if (bus.rx_empty) n_viol++;
    end
    if (bus.wr_uart) begin
      tx_q.push_back(bus.w_data);
      tx_cyc.push_back(cyc);
      if (bus.tx_full) n_viol++;
    end
    if (bus.rd_uart && bus.wr_uart) n_viol++;
  end

  // RX FIFO model: sole driver of rx_empty/r_data, updated just after each edge.
  always @(posedge CLK) begin
    logic [7:0] tmp;
    #1;
    if (pop_req) begin
      pop_req = 1'b0;
      if (rx_q.size() > 0) tmp = rx_q.pop_front();
    end
    while (pend_q.size() > 0) begin
      tmp = pend_q.pop_front();
      rx_q.push_back(tmp);
    end
    bus.rx_empty = (rx_q.size() == 0);
    bus.r_data   = (rx_q.size() == 0) ? 8'h00 : rx_q[0];
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic sync();
    @(posedge CLK);
    #2;
  endtask

  task automatic push_byte(input logic [7:0] b);
    pend_q.push_back(b);
  endtask

  task automatic clear_logs();
    rd_cyc.delete();
    tx_q.delete();
    tx_cyc.delete();
  endtask

  task automatic wait_tx(input int n, input int budget);
    for (int i = 0; i < budget && tx_q.size() < n; i++) @(negedge CLK);
    if (tx_q.size() < n) chk("tx_timeout", tx_q.size(), n);
  endtask

  task automatic wait_rd(input int n, input int budget);
    for (int i = 0; i < budget && rd_cyc.size() < n; i++) @(negedge CLK);
    if (rd_cyc.size() < n) chk("rd_timeout", rd_cyc.size(), n);
  endtask

  function automatic logic [31:0] tx_at(input int i);
    return (tx_q.size() > i) ? {24'h0, tx_q[i]} : 32'hxxxx_xxxx;
  endfunction

  function automatic logic [31:0] rd_gap(input int i);
    return (rd_cyc.size() > i) ? rd_cyc[i] - rd_cyc[i-1] : 32'hxxxx_xxxx;
  endfunction

  function automatic logic [31:0] tx_latency();
    return (tx_cyc.size() > 0 && rd_cyc.size() >= 3) ? tx_cyc[0] - rd_cyc[2] : 32'hxxxx_xxxx;
  endfunction

  initial begin
    vec_t vt[6];
    int   bad;
    int   rel;
    vt[0] = '{8'h05, 8'h03, 8'h20, 8'h08, 6'h20};
    vt[1] = '{8'h0A, 8'h04, 8'h22, 8'h06, 6'h22};
    vt[2] = '{8'hFF, 8'h01, 8'h20, 8'h00, 6'h20};
    vt[3] = '{8'h07, 8'h09, 8'hE0, 8'h10, 6'h20};
    vt[4] = '{8'hFF, 8'h01, 8'h22, 8'hFE, 6'h22};
    vt[5] = '{8'h33, 8'h44, 8'h01, 8'h00, 6'h01};

    // Reset with data already waiting in the RX FIFO.
    push_byte(8'h05);
    repeat (3) sync();
    chk("rst_rd_uart", bus.rd_uart, 0);
    chk("rst_wr_uart", bus.wr_uart, 0);
    chk("rst_busy",    bus.busy,    0);
    chk("rst_alu_a",   bus.alu_a,   0);
    chk("rst_alu_b",   bus.alu_b,   0);
    chk("rst_alu_op",  bus.alu_op,  0);
    chk("rst_w_data",  bus.w_data,  0);
    RESET = 1'b1;
    #1;
    chk("no_strobe_before_edge", bus.rd_uart, 0);

    push_byte(8'h03);
    push_byte(8'h20);
    wait_tx(1, 50);
    repeat (3) sync();
    chk("first_rd_count", rd_cyc.size(), 3);
    chk("first_alu_a",    bus.alu_a,     8'h05);
    chk("first_alu_b",    bus.alu_b,     8'h03);
    chk("first_alu_op",   bus.alu_op,    6'h20);
    chk("first_tx_count", tx_q.size(),   1);
    chk("first_w_data",   tx_at(0),      8'h08);
    chk("first_latency",  tx_latency(),  2);

    for (int v = 0; v < 6; v++) begin
      clear_logs();
      push_byte(vt[v].a);
      push_byte(vt[v].b);
      push_byte(vt[v].op);
      wait_tx(1, 50);
      repeat (3) sync();
      chk("vec_rd_count", rd_cyc.size(), 3);
      chk("vec_alu_a",    bus.alu_a,     vt[v].a);
      chk("vec_alu_b",    bus.alu_b,     vt[v].b);
      chk("vec_alu_op",   bus.alu_op,    vt[v].exp_op);
      chk("vec_tx_count", tx_q.size(),   1);
      chk("vec_result",   tx_at(0),      vt[v].res);
      chk("vec_w_data",   bus.w_data,    vt[v].res);
      chk("vec_latency",  tx_latency(),  2);
      chk("vec_idle",     bus.busy,      0);
    end

    // Six bytes preloaded: back-to-back pops, two results in order.
    clear_logs();
    push_byte(8'h0A); push_byte(8'h04); push_byte(8'h22);
    push_byte(8'hFF); push_byte(8'h01); push_byte(8'h20);
    wait_tx(2, 100);
    repeat (3) sync();
    chk("b2b_rd_count", rd_cyc.size(), 6);
    chk("b2b_gap1",     rd_gap(1),     1);
    chk("b2b_gap2",     rd_gap(2),     1);
    chk("b2b_gap4",     rd_gap(4),     1);
    chk("b2b_gap5",     rd_gap(5),     1);
    chk("b2b_reenter",  (rd_cyc.size() > 3 && tx_cyc.size() > 0) ? rd_cyc[3] - tx_cyc[0] : 32'hxxxx_xxxx, 1);
    chk("b2b_tx_count", tx_q.size(),   2);
    chk("b2b_res0",     tx_at(0),      8'h06);
    chk("b2b_res1",     tx_at(1),      8'h00);

    // TX FIFO full for 50 cycles of SEND.
    clear_logs();
    bus.tx_full = 1'b1;
    push_byte(8'h05); push_byte(8'h03); push_byte(8'h20);
    wait_rd(3, 50);
    @(negedge CLK);
    bad = 0;
    for (int i = 0; i < 50; i++) begin
      @(negedge CLK);
      if (bus.wr_uart !== 1'b0 || bus.busy !== 1'b1 || bus.w_data !== 8'h08) bad++;
    end
    chk("full_hold", bad, 0);
    @(posedge CLK);
    #1;
    rel = cyc;
    bus.tx_full = 1'b0;
    wait_tx(1, 10);
    repeat (3) sync();
    chk("full_tx_count", tx_q.size(), 1);
    chk("full_result",   tx_at(0),    8'h08);
    chk("full_release",  (tx_cyc.size() > 0) ? tx_cyc[0] - rel : 32'hxxxx_xxxx, 1);

    // Reset in the middle of a transaction.
    clear_logs();
    push_byte(8'h11); push_byte(8'h22);
    wait_rd(2, 20);
    sync();
    RESET = 1'b0;
    #1;
    chk("midrst_alu_a",   bus.alu_a,   0);
    chk("midrst_alu_b",   bus.alu_b,   0);
    chk("midrst_rd_uart", bus.rd_uart, 0);
    repeat (3) sync();
    RESET = 1'b1;
    clear_logs();
    push_byte(8'h02); push_byte(8'h02); push_byte(8'h20);
    wait_tx(1, 50);
    repeat (3) sync();
    chk("midrst_new_a",    bus.alu_a,   8'h02);
    chk("midrst_new_b",    bus.alu_b,   8'h02);
    chk("midrst_tx_count", tx_q.size(), 1);
    chk("midrst_result",   tx_at(0),    8'h04);

    // Bytes paced 3000 cycles apart.
    clear_logs();
    push_byte(8'h07);
    repeat (3000) sync();
    chk("paced_rd1",   rd_cyc.size(), 1);
    chk("paced_a",     bus.alu_a,     8'h07);
    chk("paced_idle1", bus.busy,      0);
    push_byte(8'h04);
    repeat (3000) sync();
    chk("paced_rd2",   rd_cyc.size(), 2);
    chk("paced_idle2", bus.busy,      0);
    chk("paced_tx0",   tx_q.size(),   0);
    push_byte(8'h20);
    wait_tx(1, 3000);
    repeat (3) sync();
    chk("paced_rd3",      rd_cyc.size(), 3);
    chk("paced_tx_count", tx_q.size(),   1);
    chk("paced_result",   tx_at(0),      8'h0B);

    chk("protocol_violations", n_viol, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/uart_alu_ctrl.md
UART_ALU_CTRL -- requirements
Module: uart_alu_ctrl

Interface
REQ-001 Parameter DATA_W, default 8, width of operands, result and UART data bytes.
REQ-002 Parameter OP_W, default 6, width of ALU opcode; OP_W SHALL be <= DATA_W.
REQ-003 CLK  input  1  single system clock; all state updates on rising edge.
REQ-004 RESET  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-005 rx_empty  input  1  UART receive FIFO empty flag.
REQ-006 r_data  input  DATA_W  UART receive FIFO head word, valid while rx_empty=0.
REQ-007 rd_uart  output  1  one-cycle pop strobe to UART receive FIFO.
REQ-008 tx_full  input  1  UART transmit FIFO full flag.
REQ-009 wr_uart  output  1  one-cycle push strobe to UART transmit FIFO.
REQ-010 w_data  output  DATA_W  byte pushed to transmit FIFO, valid while wr_uart=1.
REQ-011 alu_a  output  DATA_W  registered operand A to external combinational ALU.
REQ-012 alu_b  output  DATA_W  registered operand B to ALU.
REQ-013 alu_op  output  OP_W  registered opcode to ALU.
REQ-014 alu_result  input  DATA_W  combinational ALU result for current alu_a/alu_b/alu_op.
REQ-015 busy  output  1  high in EXEC and SEND states.

Function
REQ-016 FSM states SHALL be WAIT_A, WAIT_B, WAIT_OP, EXEC, SEND; encoding free.
REQ-017 In WAIT_A/WAIT_B/WAIT_OP with rx_empty=0: rd_uart=1 combinationally that cycle, r_data captured at the clock edge into alu_a / alu_b / alu_op (r_data[OP_W-1:0], upper bits discarded), and state advances to WAIT_B / WAIT_OP / EXEC respectively.
REQ-018 In WAIT_* with rx_empty=1: rd_uart=0, state and registers hold.
REQ-019 rd_uart SHALL never be asserted outside WAIT_* states nor while rx_empty=1.
REQ-020 Back-to-back bytes: a WAIT_* state entered with rx_empty=0 SHALL pop in its first cycle; no idle cycle required between pops.
REQ-021 EXEC lasts exactly one cycle; alu_result captured into internal result register at its end; state -> SEND.
REQ-022 In SEND with tx_full=0: wr_uart=1 for exactly that cycle, w_data=result register, state -> WAIT_A.
REQ-023 In SEND with tx_full=1: wr_uart=0, state holds until tx_full=0; result register SHALL not change.
REQ-024 w_data SHALL equal the result register at all times (registered output, stable outside wr_uart).
REQ-025 alu_a, alu_b, alu_op SHALL hold their last captured values until overwritten by a new pop.
REQ-026 Latency: wr_uart asserted no earlier than 2 cycles after the opcode pop cycle (EXEC, then SEND), exactly 2 when tx_full=0.
REQ-027 rd_uart and wr_uart SHALL never be high in the same cycle.

Reset
REQ-028 RESET=0 SHALL immediately force state=WAIT_A, alu_a=0, alu_b=0, alu_op=0, result register=0, w_data=0, busy=0, rd_uart=0, wr_uart=0, independent of CLK.
REQ-029 Reset asserted mid-transaction SHALL discard any partially received operands; the first pop after release is treated as operand A.
REQ-030 After RESET rises, no strobe SHALL be issued before the first rising CLK edge.

Verification
REQ-031 Push 0x05, 0x03, 0x20 into RX model, ALU stub = A+B for op 0x20 -> exactly three rd_uart pulses, alu_a=0x05, alu_b=0x03, alu_op=0x20, one wr_uart pulse with w_data=0x08 two cycles after third pop.
REQ-032 Same transaction with tx_full held 1 for 50 cycles after EXEC -> wr_uart stays 0, busy=1 throughout, single wr_uart with w_data=0x08 in first cycle tx_full=0.
REQ-033 Six bytes preloaded (0x0A,0x04,0x22, 0xFF,0x01,0x20; stub 0x22=A-B) -> pops in consecutive cycles per operand group, outputs 0x06 then 0x00 in order, no extra strobes.
REQ-034 Opcode byte 0xE0 -> alu_op=0x20 (bits [7:6] dropped), result as for 0x20.
REQ-035 Pop 0x11, 0x22, then pulse RESET=0 for 3 cycles, then send 0x02, 0x02, 0x20 -> alu_a=0x02, w_data=0x04; no wr_uart from the aborted transaction.
REQ-036 Bytes arriving 3000 cycles apart (UART bit-rate pacing) -> rd_uart only when rx_empty=0, state holds in WAIT_* between bytes, single correct result.
